// File: rtl/unified_mem_arbiter_if.sv
// Fetch port, data port and memory-side signals of the unified memory arbiter.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [31:0]       if_rdata;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              stall_if;
  logic              stall_mem;
  logic              busy;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid, mem_en, mem_we, mem_addr,
           mem_wdata, stall_if, stall_mem, busy
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid, mem_en, mem_we, mem_addr,
           mem_wdata, stall_if, stall_mem, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous-read memory between instruction fetch and
// load/store; data has priority, bounded by a fetch anti-starvation limit.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);
  localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [2:0]      lat_cnt;
  logic [SC_W-1:0] starve_cnt;
  logic            sel_d;
  logic            sel_we;
  logic            flushed;
  logic            fetch_win;

  always_comb begin
    fetch_win = bus.if_req & (~bus.d_req | (starve_cnt == SC_W'(STARVE_MAX)));
  end

  assign bus.stall_if  = bus.if_req & ~bus.if_valid;
  assign bus.stall_mem = bus.d_req & ~bus.d_valid;
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      starve_cnt    <= '0;
      sel_d         <= 1'b0;
      sel_we        <= 1'b0;
      flushed       <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.if_valid  <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_valid   <= 1'b0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.if_req) starve_cnt <= '0;
          if (bus.if_req || bus.d_req) begin
            state      <= ISSUE;
            bus.mem_en <= 1'b1;
            flushed    <= 1'b0;
            if (fetch_win) begin
              sel_d        <= 1'b0;
              sel_we       <= 1'b0;
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= bus.if_addr[ADDR_W-1:2];
              starve_cnt   <= '0;
            end else begin
              sel_d         <= 1'b1;
              sel_we        <= bus.d_we;
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr[ADDR_W-1:2];
              bus.mem_wdata <= bus.d_wdata;
              if (bus.if_req && starve_cnt != SC_W'(STARVE_MAX))
                starve_cnt <= starve_cnt + SC_W'(1);
            end
          end
        end
        ISSUE: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          flushed    <= bus.if_flush;
          // WAIT covers MEM_LAT-1 cycles so that RESP's exit edge is the capture edge
          lat_cnt    <= 3'(MEM_LAT - 1);
          state      <= (MEM_LAT > 1) ? WAIT : RESP;
        end
        WAIT: begin
          flushed <= flushed | bus.if_flush;
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          if (sel_d) begin
            bus.d_valid <= 1'b1;
            if (!sel_we) bus.d_rdata <= bus.mem_rdata;
          end else if (!(flushed || bus.if_flush)) begin
            bus.if_valid <= 1'b1;
            bus.if_rdata <= bus.mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed scenarios then random
// fetch/load/store traffic against a transaction-level reference model.
module tb_unified_mem_arbiter;
  localparam int LAT    = 3;
  localparam int STARVE = 4;

  logic clk;
  logic rst;

  unified_mem_arbiter_if #(.ADDR_W(8)) bus ();

  unified_mem_arbiter #(
    .ADDR_W    (8),
    .MEM_LAT   (LAT),
    .STARVE_MAX(STARVE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'h0050_0093;
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  // Memory: synchronous read with LAT cycles from sample edge to data
  logic [31:0] mem [64];
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : $urandom;
  end
  assign bus.mem_rdata = rd_pipe[LAT-1];

  // Reference model: one transaction at a time, each LAT+2 edges long
  typedef struct {
    int          cyc;
    bit          port;
    logic [31:0] data;
    bit          drop;
    logic [31:0] prev;
  } exp_t;

  exp_t        exp_q[$];
  int          edge_no = 0;
  logic [31:0] ref_mem [64];
  bit          m_active, m_is_d, m_drop, m_if_done, m_d_done;
  int          m_grant, m_starve;
  logic [31:0] m_last_if, m_last_d, m_data;
  logic [5:0]  m_w;

  always @(posedge clk) begin
    edge_no++;
    m_if_done = 1'b0;
    m_d_done  = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_active  = 1'b0;
      m_starve  = 0;
      m_last_if = '0;
      m_last_d  = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    end else begin
      if (m_active) begin
        if (!m_is_d && bus.if_flush && edge_no <= m_grant + LAT + 1 && !m_drop) begin
          m_drop = 1'b1;
          exp_q[exp_q.size()-1].drop = 1'b1;
        end
        if (edge_no == m_grant + LAT + 1) begin
          if (m_is_d) m_d_done = 1'b1;
          else begin
            m_if_done = 1'b1;
            if (!m_drop) m_last_if = m_data;
          end
        end
        if (edge_no == m_grant + LAT + 2) m_active = 1'b0;
      end
      if (!m_active) begin
        if (!bus.if_req) m_starve = 0;
        if (bus.if_req || bus.d_req) begin
          m_active = 1'b1;
          m_grant  = edge_no;
          m_drop   = 1'b0;
          m_is_d   = bus.d_req && !(bus.if_req && m_starve >= STARVE);
          if (m_is_d) begin
            if (bus.if_req) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
            m_w = bus.d_addr[7:2];
            if (bus.d_we) begin
              ref_mem[m_w] = bus.d_wdata;
              m_data = m_last_d;
            end else begin
              m_data   = ref_mem[m_w];
              m_last_d = m_data;
            end
          end else begin
            m_starve = 0;
            m_w      = bus.if_addr[7:2];
            m_data   = ref_mem[m_w];
          end
          exp_q.push_back('{cyc: edge_no + LAT + 1, port: m_is_d, data: m_data,
                            drop: 1'b0, prev: m_last_if});
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response is due or presented
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      check("mem_we_without_en", 32'(bus.mem_we & ~bus.mem_en), 32'd0);
      while (exp_q.size() != 0 && exp_q[0].cyc < edge_no) begin
        check("missed_response_cycle", edge_no, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() != 0 && exp_q[0].cyc == edge_no) begin
        mon_e = exp_q.pop_front();
        if (mon_e.drop) begin
          check("flushed_valid", {bus.if_valid, bus.d_valid}, 32'd0);
          check("flushed_if_rdata", bus.if_rdata, mon_e.prev);
        end else begin
          check("valid_port", {bus.if_valid, bus.d_valid}, mon_e.port ? 32'd1 : 32'd2);
          if (mon_e.port) check("d_rdata", bus.d_rdata, mon_e.data);
          else            check("if_rdata", bus.if_rdata, mon_e.data);
        end
      end else if (bus.if_valid || bus.d_valid) begin
        check("unexpected_valid", {bus.if_valid, bus.d_valid}, 32'd0);
      end
    end
  end

  // Stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic        s_en, s_we, s_en1, s_stall0, s_stallv;
  logic [5:0]  s_addr;
  logic [31:0] s_wdata;

  task automatic access(input bit is_d, input bit we, input logic [7:0] a,
                        input logic [31:0] wd, output int lat, output int bcnt);
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = a;
    end
    lat  = -1;
    bcnt = 0;
    tick();
    for (int t = 0; t < 16; t++) begin
      if (t == 0) begin
        s_en = bus.mem_en; s_we = bus.mem_we; s_addr = bus.mem_addr; s_wdata = bus.mem_wdata;
        s_stall0 = is_d ? bus.stall_mem : bus.stall_if;
      end
      if (t == 1) s_en1 = bus.mem_en;
      if (bus.busy) bcnt++;
      if (is_d ? bus.d_valid : bus.if_valid) begin
        lat = t;
        s_stallv = is_d ? bus.stall_mem : bus.stall_if;
        break;
      end
      tick();
    end
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
  endtask

  int lat, bcnt, dv_t, iv_t, bad, k, seen;

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) tick();
    check("rst_ctrl", {bus.mem_en, bus.mem_we, bus.if_valid, bus.d_valid, bus.busy}, 32'd0);
    check("rst_data", bus.if_rdata | bus.d_rdata | bus.mem_wdata | 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    tick();

    // Single fetch
    access(1'b0, 1'b0, 8'h04, 32'd0, lat, bcnt);
    check("fetch_issue_en_we", {s_en, s_we}, 32'd2);
    check("fetch_issue_addr", s_addr, 32'd1);
    check("fetch_en_one_cycle", s_en1, 32'd0);
    check("fetch_latency", lat, LAT + 1);
    check("fetch_busy_cycles", bcnt, LAT + 1);
    check("fetch_data", bus.if_rdata, 32'h0050_0093);
    check("fetch_stall_edges", {s_stall0, s_stallv}, 32'd2);

    // Store then misaligned load
    access(1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, lat, bcnt);
    check("store_issue_en_we", {s_en, s_we}, 32'd3);
    check("store_issue_addr", s_addr, 32'd4);
    check("store_issue_wdata", s_wdata, 32'hDEAD_BEEF);
    check("store_latency", lat, LAT + 1);
    check("store_d_rdata_kept", bus.d_rdata, 32'd0);
    check("store_stall_edges", {s_stall0, s_stallv}, 32'd2);
    access(1'b1, 1'b0, 8'h13, 32'd0, lat, bcnt);
    check("load_issue_addr", s_addr, 32'd4);
    check("load_data", bus.d_rdata, 32'hDEAD_BEEF);

    // Simultaneous requests: data first, then fetch
    bus.if_req = 1'b1; bus.if_addr = 8'h08;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h10;
    dv_t = -1; iv_t = -1; bad = 0;
    tick();
    for (int t = 0; t < 2 * LAT + 5; t++) begin
      if (t == 0) check("prio_first_addr", bus.mem_addr, 32'd4);
      if (bus.d_valid) dv_t = t;
      if (bus.if_valid) iv_t = t;
      if (bus.stall_if != (t < 2 * LAT + 3)) bad++;
      if (bus.d_valid) bus.d_req = 1'b0;
      if (bus.if_valid) bus.if_req = 1'b0;
      tick();
    end
    check("prio_d_valid_cycle", dv_t, LAT + 1);
    check("prio_if_valid_cycle", iv_t, 2 * LAT + 3);
    check("prio_stall_if_profile", bad, 32'd0);

    // Both held continuously: STARVE data grants, then one fetch
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h20;
    bus.if_req = 1'b1; bus.if_addr = 8'h08;
    k = 0; bad = 0;
    for (int t = 0; t < 200 && k < 15; t++) begin
      tick();
      if (bus.d_valid || bus.if_valid) begin
        if (bus.if_valid != ((k % (STARVE + 1)) == STARVE)) bad++;
        k++;
        if (k == 15) begin bus.d_req = 1'b0; bus.if_req = 1'b0; end
      end
    end
    check("starve_grants_seen", k, 32'd15);
    check("starve_pattern_errors", bad, 32'd0);

    // Flush during WAIT drops the fetch
    bus.if_req = 1'b1; bus.if_addr = 8'h0C;
    tick();
    tick();
    bus.if_flush = 1'b1;
    tick();
    bus.if_flush = 1'b0; bus.if_req = 1'b0;
    seen = 0;
    for (int t = 0; t < LAT + 4; t++) begin
      if (bus.if_valid) seen++;
      tick();
    end
    check("flush_no_if_valid", seen, 32'd0);
    check("flush_if_rdata_kept", bus.if_rdata, init_word(2));
    access(1'b0, 1'b0, 8'h08, 32'd0, lat, bcnt);
    check("post_flush_latency", lat, LAT + 1);
    check("post_flush_data", bus.if_rdata, init_word(2));

    // Asynchronous reset in the middle of WAIT
    bus.if_req = 1'b1; bus.if_addr = 8'h40;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("midrst_ctrl", {bus.mem_en, bus.mem_we, bus.if_valid, bus.d_valid, bus.busy}, 32'd0);
    check("midrst_data", bus.if_rdata | bus.d_rdata | bus.mem_wdata | 32'(bus.mem_addr), 32'd0);
    bus.if_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    seen = 0;
    for (int t = 0; t < LAT + 4; t++) begin
      if (bus.if_valid || bus.d_valid) seen++;
      tick();
    end
    check("midrst_no_valid", seen, 32'd0);
    access(1'b0, 1'b0, 8'h04, 32'd0, lat, bcnt);
    check("postrst_fetch_latency", lat, LAT + 1);
    check("postrst_fetch_data", bus.if_rdata, 32'h0050_0093);

    // Random traffic, requesters obey hold-until-complete
    for (int c = 0; c < 2500; c++) begin
      bus.if_flush = ($urandom_range(0, 9) == 0);
      if (m_if_done) begin
        if ($urandom_range(0, 2) == 0) bus.if_req = 1'b0;
        else bus.if_addr = 8'($urandom);
      end else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1'b1; bus.if_addr = 8'($urandom);
      end
      if (m_d_done || (!bus.d_req && $urandom_range(0, 2) == 0)) begin
        if (m_d_done && $urandom_range(0, 2) == 0) bus.d_req = 1'b0;
        else begin
          bus.d_req = 1'b1; bus.d_we = 1'($urandom);
          bus.d_addr = 8'($urandom_range(0, 63)); bus.d_wdata = $urandom;
        end
      end
      tick();
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.if_flush = 1'b0;
    repeat (LAT + 6) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
